lock_key_loader: RTL and testbench

Sequential key-provisioning stage that sits directly upstream of the locked combinational netlists in this benchmark set (e.g. the 16-key `rll16` circuits). It receives a key serially over a valid/ready stream, checks it with a parity bit, and then holds it stable on a parallel bus wired one-to-one onto the locked circuit's `keyIn_0_*` inputs. Until a valid key is armed, the bus drives a decoy pattern. Repeated bad loads latch the block into lockout.

---
 rtl/lock_key_pkg.sv | 24 ++
 rtl/key_shift_reg.sv | 45 ++++
 rtl/lock_key_loader.sv | 159 +++++++++++++++
 tb/tb_lock_key_loader.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/lock_key_pkg.sv
// Shared types and constants for the key loader and its serial shift register.
package lock_key_pkg;

  // Default width of the key bus feeding the locked netlist.
  localparam int LK_KEY_WIDTH = 16;

  // Width of the consecutive-failure counter.
  localparam int FAIL_CNT_W = 4;

  // Loader states.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SHIFT   = 3'd1,
    CHECK   = 3'd2,
    ARMED   = 3'd3,
    LOCKOUT = 3'd4
  } lk_state_t;

  // One step of a running even-parity accumulator.
  function automatic logic parity_step(input logic acc, input logic bit_in);
    return acc ^ bit_in;
  endfunction

endpackage

// File: rtl/key_shift_reg.sv
// LSB-first serial-in / parallel-out register with a running parity bit.
// A data shift stores the bit and folds it into the parity; a parity-only
// step folds the trailing parity beat in without disturbing the data.
module key_shift_reg
  import lock_key_pkg::*;
#(
  parameter int WIDTH = LK_KEY_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_shift,
  input  logic             i_par_only,
  input  logic             i_bit,
  output logic [WIDTH-1:0] o_data,
  output logic             o_parity
);

  logic [WIDTH-1:0] r_data;
  logic             r_parity;

  // Shift new bits in at the MSB so the first bit ends up in bit 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data   <= {WIDTH{1'b0}};
      r_parity <= 1'b0;
    end else if (i_clr) begin
      r_data   <= {WIDTH{1'b0}};
      r_parity <= 1'b0;
    end else if (i_shift) begin
      r_data   <= {i_bit, r_data[WIDTH-1:1]};
      r_parity <= parity_step(r_parity, i_bit);
    end else if (i_par_only) begin
      r_data   <= r_data;
      r_parity <= parity_step(r_parity, i_bit);
    end else begin
      r_data   <= r_data;
      r_parity <= r_parity;
    end
  end

  assign o_data   = r_data;
  assign o_parity = r_parity;

endmodule

// File: rtl/lock_key_loader.sv
// Serial key provisioning stage: receives a parity-protected key over a
// valid/ready stream, arms it onto a stable parallel bus, drives a decoy
// otherwise, and locks out after repeated bad loads.
module lock_key_loader
  import lock_key_pkg::*;
#(
  parameter int                  KEY_WIDTH = LK_KEY_WIDTH,
  parameter logic [KEY_WIDTH-1:0] DECOY_KEY = {KEY_WIDTH{1'b0}},
  parameter int                  MAX_FAILS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  s_valid,
  input  logic                  s_data,
  output logic                  s_ready,
  input  logic                  zeroize,
  output logic [KEY_WIDTH-1:0]  key_out,
  output logic                  key_valid,
  output logic                  load_err,
  output logic                  locked,
  output logic [FAIL_CNT_W-1:0] fail_cnt
);

  localparam int CNT_W = $clog2(KEY_WIDTH + 1);

  lk_state_t               r_state;
  lk_state_t               w_state_nxt;
  logic [CNT_W-1:0]        r_cnt;
  logic [CNT_W-1:0]        w_cnt_nxt;
  logic [KEY_WIDTH-1:0]    r_hold;
  logic [KEY_WIDTH-1:0]    w_hold_nxt;
  logic [FAIL_CNT_W-1:0]   r_fail;
  logic [FAIL_CNT_W-1:0]   w_fail_nxt;
  logic [FAIL_CNT_W-1:0]   w_fail_inc;
  logic                    w_err_nxt;
  logic                    w_clr;
  logic                    w_shift;
  logic                    w_par_only;
  logic [KEY_WIDTH-1:0]    w_sr_data;
  logic                    w_sr_parity;
  logic                    r_s_ready;
  logic                    r_key_valid;
  logic                    r_load_err;
  logic                    r_locked;
  logic [KEY_WIDTH-1:0]    r_key_out;

  key_shift_reg #(
    .WIDTH (KEY_WIDTH)
  ) u_shift (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clr      (w_clr),
    .i_shift    (w_shift),
    .i_par_only (w_par_only),
    .i_bit      (s_data),
    .o_data     (w_sr_data),
    .o_parity   (w_sr_parity)
  );

  assign w_fail_inc = r_fail + {{(FAIL_CNT_W-1){1'b0}}, 1'b1};

  // Next-state, shift-control and bookkeeping logic; zeroize outranks everything but lockout.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_hold_nxt  = r_hold;
    w_fail_nxt  = r_fail;
    w_err_nxt   = 1'b0;
    w_clr       = 1'b0;
    w_shift     = 1'b0;
    w_par_only  = 1'b0;
    if (zeroize && (r_state != LOCKOUT)) begin
      w_state_nxt = IDLE;
      w_cnt_nxt   = {CNT_W{1'b0}};
      w_hold_nxt  = {KEY_WIDTH{1'b0}};
      w_clr       = 1'b1;
    end else begin
      case (r_state)
        IDLE, ARMED: begin
          if (start) begin
            w_state_nxt = SHIFT;
            w_cnt_nxt   = {CNT_W{1'b0}};
            w_clr       = 1'b1;
          end else begin
            w_state_nxt = r_state;
          end
        end
        SHIFT: begin
          if (s_valid) begin
            if (r_cnt == CNT_W'(KEY_WIDTH)) begin
              w_par_only  = 1'b1;
              w_state_nxt = CHECK;
            end else begin
              w_shift   = 1'b1;
              w_cnt_nxt = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
          end else begin
            w_state_nxt = SHIFT;
          end
        end
        CHECK: begin
          if (!w_sr_parity) begin
            w_hold_nxt  = w_sr_data;
            w_fail_nxt  = {FAIL_CNT_W{1'b0}};
            w_state_nxt = ARMED;
          end else begin
            w_err_nxt  = 1'b1;
            w_fail_nxt = w_fail_inc;
            if (w_fail_inc == FAIL_CNT_W'(MAX_FAILS)) begin
              w_state_nxt = LOCKOUT;
            end else begin
              w_state_nxt = IDLE;
            end
          end
        end
        LOCKOUT: begin
          w_state_nxt = LOCKOUT;
        end
        default: begin
          w_state_nxt = IDLE;
        end
      endcase
    end
  end

  // State, counters and registered outputs; outputs decode the next state so they align with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= {CNT_W{1'b0}};
      r_hold      <= {KEY_WIDTH{1'b0}};
      r_fail      <= {FAIL_CNT_W{1'b0}};
      r_s_ready   <= 1'b0;
      r_key_valid <= 1'b0;
      r_load_err  <= 1'b0;
      r_locked    <= 1'b0;
      r_key_out   <= DECOY_KEY;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_hold      <= w_hold_nxt;
      r_fail      <= w_fail_nxt;
      r_s_ready   <= (w_state_nxt == SHIFT);
      r_key_valid <= (w_state_nxt == ARMED);
      r_load_err  <= w_err_nxt;
      r_locked    <= (w_state_nxt == LOCKOUT);
      r_key_out   <= (w_state_nxt == ARMED) ? w_hold_nxt : DECOY_KEY;
    end
  end

  assign s_ready   = r_s_ready;
  assign key_valid = r_key_valid;
  assign load_err  = r_load_err;
  assign locked    = r_locked;
  assign fail_cnt  = r_fail;
  assign key_out   = r_key_out;

endmodule

// File: tb/tb_lock_key_loader.sv
// Self-checking bench for lock_key_loader: directed scenarios plus random
// loads, checked against a transaction-level model of the loader.
module tb_lock_key_loader;

  localparam int          KW        = 16;
  localparam logic [15:0] DECOY     = 16'h0000;
  localparam int          MAXF      = 3;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        s_valid;
  logic        s_data;
  logic        s_ready;
  logic        zeroize;
  logic [15:0] key_out;
  logic        key_valid;
  logic        load_err;
  logic        locked;
  logic [3:0]  fail_cnt;

  int n_vec;
  int n_err;

  // Behavioural model of the externally visible state.
  int          m_fail;
  bit          m_locked;
  bit          m_armed;
  logic [15:0] m_key;

  lock_key_loader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .s_valid   (s_valid),
    .s_data    (s_data),
    .s_ready   (s_ready),
    .zeroize   (zeroize),
    .key_out   (key_out),
    .key_valid (key_valid),
    .load_err  (load_err),
    .locked    (locked),
    .fail_cnt  (fail_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic model_reset();
    m_fail   = 0;
    m_locked = 0;
    m_armed  = 0;
    m_key    = 16'h0000;
  endtask

  task automatic check_state(input string tag);
    check({tag, ".key_valid"}, 32'(key_valid), 32'(m_armed));
    check({tag, ".key_out"},   32'(key_out),   32'(m_armed ? m_key : DECOY));
    check({tag, ".locked"},    32'(locked),    32'(m_locked));
    check({tag, ".fail_cnt"},  32'(fail_cnt),  32'(m_fail));
  endtask

  task automatic do_reset();
    start   = 1'b0;
    s_valid = 1'b0;
    s_data  = 1'b0;
    zeroize = 1'b0;
    rst_n   = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    model_reset();
    tick();
    check_state("reset");
    check("reset.s_ready",  32'(s_ready),  32'd0);
    check("reset.load_err", 32'(load_err), 32'd0);
  endtask

  task automatic do_zeroize();
    zeroize = 1'b1;
    tick();
    zeroize = 1'b0;
    if (!m_locked) m_armed = 0;
    check_state("zeroize");
    check("zeroize.s_ready", 32'(s_ready), 32'd0);
  endtask

  // One complete load attempt; gaps of gap_lo..gap_hi idle cycles before each beat.
  task automatic do_load(input logic [15:0] key, input logic par, input int gap_lo, input int gap_hi);
    int  cyc;
    int  gaps;
    int  g;
    bit  good;
    logic b;
    cyc  = 0;
    gaps = 0;
    start = 1'b1;
    tick();
    cyc++;
    start = 1'b0;
    if (m_locked) begin
      check("lock.s_ready", 32'(s_ready), 32'd0);
      for (int i = 0; i <= KW; i++) begin
        s_valid = 1'b1;
        s_data  = 1'(i);
        tick();
        check("lock.s_ready_beat", 32'(s_ready), 32'd0);
      end
      s_valid = 1'b0;
      tick();
      check_state("lock.after");
      return;
    end
    m_armed = 0;
    check("start.s_ready",   32'(s_ready),   32'd1);
    check("start.key_valid", 32'(key_valid), 32'd0);
    for (int i = 0; i <= KW; i++) begin
      b = (i == KW) ? par : key[i];
      g = $urandom_range(gap_hi, gap_lo);
      for (int j = 0; j < g; j++) begin
        s_valid = 1'b0;
        s_data  = 1'($urandom);
        tick();
        cyc++;
        gaps++;
        check("gap.key_out", 32'(key_out), 32'(DECOY));
      end
      s_valid = 1'b1;
      s_data  = b;
      tick();
      cyc++;
    end
    s_valid = 1'b0;
    check("check.s_ready",   32'(s_ready),   32'd0);
    check("check.key_valid", 32'(key_valid), 32'd0);
    check("check.key_out",   32'(key_out),   32'(DECOY));
    tick();
    cyc++;
    good = ((^key) ^ par) == 1'b0;
    if (good) begin
      m_fail  = 0;
      m_armed = 1;
      m_key   = key;
      check("latency", 32'(cyc), 32'(KW + 3 + gaps));
    end else begin
      m_fail++;
      if (m_fail == MAXF) m_locked = 1;
    end
    check("done.load_err", 32'(load_err), 32'(!good));
    check_state("done");
    tick();
    check("after.load_err", 32'(load_err), 32'd0);
    check_state("after");
  endtask

  initial begin
    logic [15:0] rk;
    logic        rp;
    n_vec = 0;
    n_err = 0;
    do_reset();

    // Good load with no gaps, then a stalled load of the same key.
    do_load(16'hA5C3, 1'b0, 0, 0);
    do_reset();
    do_load(16'hA5C3, 1'b0, 1, 5);

    // Parity failures up to lockout.
    do_load(16'hA5C3, 1'b1, 0, 0);
    do_load(16'hA5C3, 1'b1, 0, 2);
    do_load(16'h0F0F, 1'b1, 0, 0);
    check("lockout.locked", 32'(locked), 32'd1);
    do_load(16'hA5C3, 1'b0, 0, 0);
    do_zeroize();
    check("lockout.zeroize_locked", 32'(locked), 32'd1);
    do_reset();

    // Re-key while armed, then zeroize.
    do_load(16'hA5C3, 1'b0, 0, 0);
    do_load(16'h00FF, 1'b0, 0, 1);
    do_zeroize();

    // Reset in the middle of a load.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      s_valid = 1'b1;
      s_data  = 1'b1;
      tick();
    end
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_state("async_rst");
    check("async_rst.s_ready", 32'(s_ready), 32'd0);
    s_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    do_load(16'h1234, 1'b1, 0, 0);

    // Random loads with occasional bad parity and zeroize.
    for (int n = 0; n < 30; n++) begin
      rk = 16'($urandom);
      rp = ^rk;
      if ($urandom_range(3, 0) == 0) rp = ~rp;
      do_load(rk, rp, 0, 2);
      if ($urandom_range(5, 0) == 0) do_zeroize();
      if (m_locked && ($urandom_range(1, 0) == 0)) do_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
